// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer for the low-area execute stage.
// One operand bit is processed per cycle, LSB first, through a single
// AND/OR/full-adder slice with a carry register. SRL runs as repeated
// 1-bit right shifts. Completion is signalled with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, flush      request (sampled in IDLE), synchronous cancel
//   op[2:0]           000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT,
//                     011 SRL, 100 ADDIU, 101 illegal
//   a, b, shamt       operands and SRL shift amount
//   busy, done        in-progress flag, completion pulse
//   result, cout,     registered result, final carry, result==0,
//   zero, illegal     illegal-op flag (pulses with done)
module serial_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             illegal
);

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SRL   = 3'b011;
  localparam logic [2:0] OP_ADDIU = 3'b100;
  localparam logic [2:0] OP_ILL   = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  localparam logic [CNT_W-1:0] LP_CNT_WIDTH = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;     // working/shadow register while in RUN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_target;  // number of RUN cycles for this operation
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;

  logic             w_sub;
  logic             w_arith;
  logic             w_ai;
  logic             w_bi;
  logic             w_sum;
  logic             w_co;
  logic             w_ri;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_final;
  logic [CNT_W-1:0] w_shamt_cnt;

  // Single-bit datapath slice.
  always_comb begin
    w_sub   = (r_op == OP_SUB) || (r_op == OP_SLT);
    w_arith = w_sub || (r_op == OP_ADD) || (r_op == OP_ADDIU);
    w_ai    = r_a[0];
    w_bi    = r_b[0] ^ w_sub;
    w_sum   = w_ai ^ w_bi ^ r_carry;
    w_co    = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
    case (r_op)
      OP_AND:  w_ri = w_ai & r_b[0];
      OP_OR:   w_ri = w_ai | r_b[0];
      default: w_ri = w_sum;
    endcase
    if (r_op == OP_SRL) begin
      w_acc_next = {1'b0, r_acc[WIDTH-1:1]};
    end else begin
      w_acc_next = {w_ri, r_acc[WIDTH-1:1]};
    end
    // SLT: sign of the difference corrected by signed overflow at the MSB.
    if (r_op == OP_SLT) begin
      w_final = {{(WIDTH-1){1'b0}}, w_sum ^ (r_carry ^ w_co)};
    end else begin
      w_final = w_acc_next;
    end
    w_last = (r_cnt == (r_target - CNT_W'(1)));
    // Shift amounts at or beyond WIDTH saturate at WIDTH cycles (all zeros).
    if ({27'd0, shamt} >= 32'(WIDTH)) begin
      w_shamt_cnt = LP_CNT_WIDTH;
    end else begin
      w_shamt_cnt = CNT_W'(shamt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_AND;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_target  <= '0;
      r_carry   <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op     <= op;
            r_a      <= a;
            r_b      <= b;
            r_acc    <= a;
            r_cnt    <= '0;
            r_carry  <= (op == OP_SUB) || (op == OP_SLT);
            r_target <= (op == OP_SRL) ? w_shamt_cnt : LP_CNT_WIDTH;
            if (op == OP_ILL) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_illegal <= 1'b1;
              r_result  <= '0;
              r_zero    <= 1'b1;
              r_cout    <= 1'b0;
            end else if (op == OP_SRL && shamt == 5'd0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= a;
              r_zero   <= (a == '0);
              r_cout   <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            // Visible outputs were never touched, so they keep old values.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_co;
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_acc   <= w_acc_next;
            if (w_last) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_final;
              r_zero   <= (w_final == '0);
              r_cout   <= w_arith ? w_co : 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign cout    = r_cout;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule
